// File: rtl/enigma_pkg.sv
// enigma_pkg: shared definitions for the Enigma rotor stepping stage.
//   NUM_LETTERS / LW  : alphabet size and letter/position width
//   letter_t          : one letter or rotor position
//   stepper_state_e   : stepping FSM states
//   ROTOR_R/M/L       : rotor index constants (also the load_sel encoding)
//   inc_mod26         : position increment with wrap 25 -> 0
package enigma_pkg;

   localparam int unsigned NUM_LETTERS = 26;
   localparam int unsigned LW          = 5;

   typedef logic [LW-1:0] letter_t;

   typedef enum logic [1:0] {
      IDLE,
      STEP,
      PRESENT
   } stepper_state_e;

   localparam int unsigned ROTOR_R = 0;
   localparam int unsigned ROTOR_M = 1;
   localparam int unsigned ROTOR_L = 2;

   function automatic letter_t inc_mod26(input letter_t v);
      return (v == letter_t'(NUM_LETTERS - 1)) ? '0 : v + letter_t'(1);
   endfunction

endpackage

// File: rtl/enigma_rotor_stepper_if.sv
// enigma_rotor_stepper_if: letter handshakes around the rotor stepper.
//   in_valid/in_ready/in_letter          : upstream letter channel
//   out_valid/out_ready/out_letter/
//   out_bypass                            : channel towards the cipher core
// Modports: master = the environment (source/sink), slave = the stepper.
interface enigma_rotor_stepper_if #(
   parameter int unsigned LW = enigma_pkg::LW
);
   logic          in_valid;
   logic          in_ready;
   logic [LW-1:0] in_letter;
   logic          out_valid;
   logic          out_ready;
   logic [LW-1:0] out_letter;
   logic          out_bypass;

   modport master (
      output in_valid, in_letter, out_ready,
      input  in_ready, out_valid, out_letter, out_bypass
   );

   modport slave (
      input  in_valid, in_letter, out_ready,
      output in_ready, out_valid, out_letter, out_bypass
   );
endinterface

// File: rtl/enigma_rotor_pos.sv
// enigma_rotor_pos: one rotor position register, modulo NUM_LETTERS.
//   clk, rst  : clock, asynchronous active-high reset (position -> 0)
//   load_en   : load load_pos (values >= NUM_LETTERS reduced once)
//   load_pos  : start position
//   inc_en    : advance by one, wrapping NUM_LETTERS-1 -> 0
//   notch     : notch position of this rotor
//   pos       : current position
//   at_notch  : current position equals notch
module enigma_rotor_pos
   import enigma_pkg::*;
#(
   parameter int unsigned NUM_LETTERS = enigma_pkg::NUM_LETTERS,
   parameter int unsigned LW          = enigma_pkg::LW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_en,
   input  logic [LW-1:0] load_pos,
   input  logic          inc_en,
   input  logic [LW-1:0] notch,
   output logic [LW-1:0] pos,
   output logic          at_notch
);

   localparam logic [LW-1:0] LAST = LW'(NUM_LETTERS - 1);
   localparam logic [LW-1:0] NL   = LW'(NUM_LETTERS);

   logic [LW-1:0] pos_q;
   logic [LW-1:0] load_val;
   logic [LW-1:0] inc_val;

   always_comb begin
      load_val = (load_pos > LAST) ? load_pos - NL : load_pos;
      inc_val  = (pos_q == LAST) ? '0 : pos_q + LW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pos_q <= '0;
      end else if (load_en) begin
         pos_q <= load_val;
      end else if (inc_en) begin
         pos_q <= inc_val;
      end
   end

   assign pos      = pos_q;
   assign at_notch = (pos_q == notch);

endmodule

// File: rtl/enigma_rotor_stepper.sv
// enigma_rotor_stepper: accepts one letter per handshake, steps the three
// rotors Enigma-style and presents letter + post-step positions to the
// cipher core from a one-entry buffer (IDLE -> STEP -> PRESENT).
//   clk, rst            : clock, asynchronous active-high reset
//   load_en/load_sel/
//   load_pos            : load one rotor start position (IDLE only);
//                         load_sel 0=right 1=middle 2=left 3=ignored
//   notch_r, notch_m    : notch positions of right and middle rotors
//   bus                 : letter handshakes (slave side)
//   pos_l, pos_m, pos_r : current rotor positions
//   step_count          : number of steps taken, wraps 65535 -> 0
// Build option: ENIGMA_DOUBLE_STEP_EN enables the middle-rotor double step;
// without it the rotors behave as a plain odometer.
module enigma_rotor_stepper
   import enigma_pkg::*;
#(
   parameter int unsigned NUM_LETTERS = enigma_pkg::NUM_LETTERS,
   parameter int unsigned LW          = enigma_pkg::LW
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_en,
   input  logic [1:0]            load_sel,
   input  logic [LW-1:0]         load_pos,
   input  logic [LW-1:0]         notch_r,
   input  logic [LW-1:0]         notch_m,
   enigma_rotor_stepper_if.slave bus,
   output logic [LW-1:0]         pos_l,
   output logic [LW-1:0]         pos_m,
   output logic [LW-1:0]         pos_r,
   output logic [15:0]           step_count
);

   localparam logic [LW-1:0] LAST = LW'(NUM_LETTERS - 1);

   stepper_state_e state_q;
   stepper_state_e state_d;

   logic [LW-1:0] letter_q;
   logic          bypass_q;
   logic [15:0]   step_count_q;

   logic accept;
   logic is_letter;
   logic step_go;
   logic mid_step;

   logic [LW-1:0] pos_arr   [3];
   logic [LW-1:0] notch_arr [3];
   logic          ld_arr    [3];
   logic          inc_arr   [3];
   logic          notch_hit [3];

   assign bus.in_ready = (state_q == IDLE) && !load_en && !rst;
   assign accept       = bus.in_valid && bus.in_ready;
   assign is_letter    = (letter_q <= LAST);
   assign step_go      = (state_q == STEP) && is_letter;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = STEP;
         STEP:    state_d = PRESENT;
         PRESENT: if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         letter_q     <= '0;
         bypass_q     <= 1'b0;
         step_count_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            letter_q <= bus.in_letter;
         end
         if (state_q == STEP) begin
            bypass_q <= !is_letter;
         end
         if (step_go) begin
            step_count_q <= step_count_q + 16'd1;
         end
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < 3; i++) begin
         ld_arr[i] = (state_q == IDLE) && load_en && (load_sel == 2'(i));
      end
   end

   always_comb begin
      notch_arr[ROTOR_R] = notch_r;
      notch_arr[ROTOR_M] = notch_m;
      notch_arr[ROTOR_L] = '0;
   end

   // All increments are decided from the pre-step positions. The left rotor
   // steps only when the middle rotor steps off its notch; with the double
   // step enabled that reduces to "middle at notch".
   always_comb begin
`ifdef ENIGMA_DOUBLE_STEP_EN
      mid_step = notch_hit[ROTOR_R] || notch_hit[ROTOR_M];
`else
      mid_step = notch_hit[ROTOR_R];
`endif
      inc_arr[ROTOR_R] = step_go;
      inc_arr[ROTOR_M] = step_go && mid_step;
      inc_arr[ROTOR_L] = step_go && mid_step && notch_hit[ROTOR_M];
   end

   for (genvar g = 0; g < 3; g++) begin : g_rotor
      enigma_rotor_pos #(
         .NUM_LETTERS (NUM_LETTERS),
         .LW          (LW)
      ) u_pos (
         .clk      (clk),
         .rst      (rst),
         .load_en  (ld_arr[g]),
         .load_pos (load_pos),
         .inc_en   (inc_arr[g]),
         .notch    (notch_arr[g]),
         .pos      (pos_arr[g]),
         .at_notch (notch_hit[g])
      );
   end

   assign bus.out_valid  = (state_q == PRESENT);
   assign bus.out_letter = letter_q;
   assign bus.out_bypass = bypass_q;
   assign pos_r          = pos_arr[ROTOR_R];
   assign pos_m          = pos_arr[ROTOR_M];
   assign pos_l          = pos_arr[ROTOR_L];
   assign step_count     = step_count_q;

endmodule

// File: doc/enigma_rotor_stepper.md
# enigma_rotor_stepper

Pipeline stage directly upstream of the Enigma cipher core. It accepts one plaintext letter per handshake, advances the three rotor positions using authentic Enigma stepping, including the double-step. It then presents the letter together with the post-step rotor positions to the cipher core through a one-entry output buffer. Rotor start positions and notch positions are loaded here, so the cipher core stays purely combinational.

## Interface
Parameters:
- `NUM_LETTERS`, default 26: alphabet size; positions and letters are held modulo this.
- `LW`, default 5: letter/position width in bits.

Ports:
- `clk`  in  1  single clock; all state on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `load_en`  in  1  load one rotor start position; honoured only in IDLE.
- `load_sel`  in  2  rotor to load: 0 = right, 1 = middle, 2 = left, 3 = ignored.
- `load_pos`  in  LW  start position; values ≥ 26 are reduced by 26.
- `notch_r`, `notch_m`  in  LW each  notch position of the right and middle rotor; static while not IDLE.
- `in_valid`  in  1  upstream letter valid.
- `in_ready`  out  1  stage can accept a letter.
- `in_letter`  in  LW  0–25 = A–Z; 26–31 = non-letter.
- `out_valid`  out  1  letter and positions valid for the cipher core.
- `out_ready`  in  1  cipher core consumes.
- `out_letter`  out  LW  accepted letter, unchanged.
- `out_bypass`  out  1  the letter was a non-letter; rotors did not step.
- `pos_l`, `pos_m`, `pos_r`  out  LW each  current rotor positions.
- `step_count`  out  16  count of steps taken; wraps at 65535 → 0.

## Operation
- FSM states: IDLE, STEP, PRESENT.
- **IDLE:** `in_ready` = !`load_en`.
  - `load_en` writes `pos_*[load_sel]`.
  - If `load_en` is high, `in_valid` is not accepted that cycle (load wins).
  - `in_valid && in_ready` captures `in_letter` and moves to STEP.
- **STEP** (exactly one cycle):
  - Letters 0–25:
    - `pos_r` increments.
    - `pos_m` increments if `pos_r == notch_r` before the step, or (double step) `pos_m == notch_m`.
    - `pos_l` increments if `pos_m == notch_m` before the step.
    - All positions wrap 25 → 0.
    - `step_count` increments by 1.
  - Letters 26–31: positions and counter unchanged; `out_bypass` = 1.
  - Moves to PRESENT.
- **PRESENT:** `out_valid` = 1 and all outputs are stable until `out_valid && out_ready`, then return to IDLE. `load_en` is ignored in STEP and PRESENT.
- Notch comparisons use the registered positions from before the step. All three increments are decided in the same cycle.

## Timing
- Letter accepted on edge N: positions update on edge N+1, and `out_valid` rises after edge N+1.
- Minimum two-edge latency; peak throughput is one letter per 3 cycles. `out_ready` held high gives one letter every 3 cycles.
- `in_ready` is combinational from the state and `load_en`. `out_valid` is registered.
- A load in IDLE is visible on `pos_*` the cycle after the edge.
- Reset values: state IDLE, all `pos_*` = 0, `out_letter` = 0, `out_valid` = 0, `out_bypass` = 0, `step_count` = 0.
- `in_ready` = 0 while `rst` is asserted.
- Reset mid-operation (STEP or PRESENT) drops the buffered letter. There is no partial output.
- Back-pressure: `out_ready` low holds PRESENT indefinitely with no change to any output.

## Configuration
- `ENIGMA_DOUBLE_STEP_EN`:
  - Defined: the middle rotor also steps when `pos_m == notch_m` (historical double-step anomaly).
  - Undefined: pure odometer behaviour. The middle rotor steps only when `pos_r == notch_r`; left-rotor behaviour is unchanged.

## Structure
- Shared package `enigma_pkg`:
  - `NUM_LETTERS`, `LW`;
  - `letter_t`;
  - the state enum `stepper_state_e`;
  - rotor index constants `ROTOR_R` / `ROTOR_M` / `ROTOR_L`;
  - function `inc_mod26`.
- One sub-module, `enigma_rotor_pos`: a single mod-26 position register with load, increment enable and an `at_notch` compare output. It is instantiated three times; the left rotor's `at_notch` is unused.

## Test plan
- Reset, then load L = 0, M = 0, R = 0 with notches R = 21, M = 4; send 'A' (0) → `out_letter` = 0, positions (0,0,1), `step_count` = 1, `out_valid` two edges after acceptance.
- Double step (macro defined): load (0,3,20), send 3 letters → positions (0,3,21), then (0,4,22), then (1,5,23).
- Macro undefined, same start (0,3,20) → (0,3,21), (0,4,22), then (0,4,23).
- Wrap: load (25,25,25), notches R = 25, M = 25 → next letter yields (0,0,0); `step_count` wraps from 0xFFFF to 0 after forced 65536 steps.
- Non-letter: send 27 from (0,0,5) → `out_bypass` = 1, positions stay (0,0,5), `step_count` unchanged.
- Handshake and loads:
  - Hold `out_ready` = 0 for 10 cycles → outputs stable and `in_ready` = 0.
  - `load_en` with `in_valid` in IDLE → load applied, letter not accepted.
  - `rst` asserted in PRESENT → `out_valid` = 0 and positions 0 immediately.
